// File: rtl/ppu_pkg.sv
// Shared PPU definitions: video timing, sprite attribute layout and the
// scheduler FSM encoding.
package ppu_pkg;

    localparam logic [10:0] HACTIVE = 11'd1280;
    localparam logic [10:0] HTOTAL  = 11'd1600;
    localparam logic [9:0]  VACTIVE = 10'd480;
    localparam logic [9:0]  VTOTAL  = 10'd525;

    localparam int ATTR_Y_LSB     = 0;
    localparam int ATTR_Y_W       = 10;
    localparam int ATTR_X_LSB     = 10;
    localparam int ATTR_X_W       = 10;
    localparam int ATTR_BASE_LSB  = 20;
    localparam int ATTR_BASE_W    = 8;
    localparam int ATTR_COLOR_LSB = 28;
    localparam int ATTR_COLOR_W   = 4;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        RD_ATTR,
        WAIT_ATTR,
        CHECK,
        RD_ROW,
        WAIT_ROW,
        LOAD,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [ATTR_COLOR_W-1:0] color;
        logic [ATTR_BASE_W-1:0]  base;
        logic [ATTR_X_W-1:0]     x;
        logic [ATTR_Y_W-1:0]     y;
    } attr_t;

    function automatic attr_t unpack_attr(input logic [31:0] word);
        attr_t a;
        a.y     = word[ATTR_Y_LSB     +: ATTR_Y_W];
        a.x     = word[ATTR_X_LSB     +: ATTR_X_W];
        a.base  = word[ATTR_BASE_LSB  +: ATTR_BASE_W];
        a.color = word[ATTR_COLOR_LSB +: ATTR_COLOR_W];
        return a;
    endfunction

endpackage

// File: rtl/sprite_hit_check.sv
// Decides whether a sprite covers a given line and which of its rows lands
// there. Pure combinational so collision logic can share it.
module sprite_hit_check #(
    parameter int SPRITE_H = 16
) (
    input  logic [9:0] t,
    input  logic [9:0] y,
    input  logic [3:0] color,
    output logic       hit,
    output logic [3:0] d
);

    logic [10:0] diff;

    // A line above the sprite wraps diff large, so the height test alone fails it.
    assign diff  = {1'b0, t} - {1'b0, y};
    assign hit   = (color != 4'd0) && (t >= y) && (diff < 11'(SPRITE_H));
    assign d     = diff[3:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans the attribute table during horizontal blanking and loads the sprite
// output slots for the next visible line, yielding table ports to the host.
module sprite_line_scheduler
    import ppu_pkg::*;
#(
    parameter int NUM_ATTRS = 16,
    parameter int NUM_SLOTS = 8,
    parameter int SPRITE_H  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 host_busy,
    output logic                 attr_rd,
    output logic [3:0]           attr_addr,
    input  logic [31:0]          attr_data,
    output logic                 spr_rd,
    output logic [7:0]           spr_addr,
    input  logic [31:0]          spr_data,
    output logic                 slot_clr,
    output logic [NUM_SLOTS-1:0] slot_ld,
    output logic [9:0]           slot_x,
    output logic [31:0]          slot_row,
    output logic [3:0]           slot_color,
    output logic                 line_ready,
    output logic                 overflow,
    output logic                 late
);

    localparam int NSW = $clog2(NUM_SLOTS + 1);

    sched_state_t   state, state_next;
    logic [3:0]     idx;
    logic [NSW-1:0] nslot;
    logic [31:0]    attr_q;
    logic [31:0]    row_q;
    attr_t          attr;
    logic [9:0]     t_line;
    logic           hit;
    logic [3:0]     d;
    logic           abort;
    logic           last_idx;
    logic           slots_full;

    assign attr       = unpack_attr(attr_q);
    assign t_line     = (vcount == VTOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
    assign abort      = (hcount == HTOTAL - 11'd1) && (state != IDLE);
    assign last_idx   = (idx == 4'(NUM_ATTRS - 1));
    assign slots_full = (nslot == NSW'(NUM_SLOTS));

    sprite_hit_check #(.SPRITE_H(SPRITE_H)) u_hit (
        .t     (t_line),
        .y     (attr.y),
        .color (attr.color),
        .hit   (hit),
        .d     (d)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: defaulting state_next before the case keeps this purely
    // combinational; an unassigned path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (hcount == HACTIVE && t_line < VACTIVE) state_next = CLEAR;
            CLEAR:     state_next = RD_ATTR;
            RD_ATTR:   if (!host_busy) state_next = WAIT_ATTR;
            WAIT_ATTR: state_next = CHECK;
            CHECK: begin
                if (hit)           state_next = slots_full ? DONE : RD_ROW;
                else if (last_idx) state_next = DONE;
                else               state_next = RD_ATTR;
            end
            RD_ROW:    if (!host_busy) state_next = WAIT_ROW;
            WAIT_ROW:  state_next = LOAD;
            LOAD:      state_next = last_idx ? DONE : RD_ATTR;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        attr_rd    = 1'b0;
        attr_addr  = 4'd0;
        spr_rd     = 1'b0;
        spr_addr   = 8'd0;
        slot_clr   = 1'b0;
        slot_ld    = '0;
        slot_x     = 10'd0;
        slot_row   = 32'd0;
        slot_color = 4'd0;
        line_ready = 1'b0;
        case (state)
            CLEAR:   slot_clr = 1'b1;
            RD_ATTR: if (!host_busy) begin
                attr_rd   = 1'b1;
                attr_addr = idx;
            end
            RD_ROW:  if (!host_busy) begin
                spr_rd   = 1'b1;
                spr_addr = attr.base + {4'd0, d};
            end
            LOAD: begin
                slot_ld    = NUM_SLOTS'(1) << nslot;
                slot_x     = attr.x;
                slot_row   = row_q;
                slot_color = attr.color;
            end
            DONE:    line_ready = !abort;
            default: ;
        endcase
    end

    // Table data is registered on the cycle after each strobe; CHECK and LOAD
    // then work from the held copies even if the host grabs the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= 4'd0;
            nslot    <= '0;
            attr_q   <= 32'd0;
            row_q    <= 32'd0;
            overflow <= 1'b0;
            late     <= 1'b0;
        end else if (abort) begin
            late <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    idx      <= 4'd0;
                    nslot    <= '0;
                    overflow <= 1'b0;
                    late     <= 1'b0;
                end
                WAIT_ATTR: attr_q <= attr_data;
                CHECK: begin
                    if (hit && slots_full)      overflow <= 1'b1;
                    else if (!hit && !last_idx) idx <= idx + 4'd1;
                end
                WAIT_ROW:  row_q <= spr_data;
                LOAD: begin
                    nslot <= nslot + NSW'(1);
                    if (!last_idx) idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
